// File: rtl/if_stage_pkg.sv
// Fetch-stage types: reset PC, buffer depth, FSM states, {pc, inst} entry.
// Buffer depth is 2 when IF_BUF2_EN is defined, otherwise 1.
`ifndef DATA_WIDTH
`include "defines.sv"
`endif
package if_stage_pkg;

    localparam logic [`DATA_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

`ifdef IF_BUF2_EN
    localparam int unsigned IF_DEPTH = 2;
`else
    localparam int unsigned IF_DEPTH = 1;
`endif

    // Holds stale-response count across back-to-back redirects.
    localparam int unsigned DROP_W = 4;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [`DATA_WIDTH-1:0] pc;
        logic [31:0]            inst;
    } buf_entry_t;

endpackage

// File: rtl/defines.sv
// Global width definitions shared by the fetch pipeline.
`ifndef IF_STAGE_DEFINES_SV
`define IF_STAGE_DEFINES_SV
`define DATA_WIDTH 64
`endif

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with flush; used for the instruction buffer and tag queue.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module if_fifo #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited requests, in-order tag queue, {pc, inst} buffer (IF_BUF2_EN: depth 2).
// Latency: grant -> inst_valid is rvalid cycle + 1; redirect -> new request the following cycle.
// Backpressure: stall holds the buffer head; inst_req drops once outstanding + buffered reaches depth.
`ifndef DATA_WIDTH
`include "defines.sv"
`endif
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [`DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   inst_req,
    output logic [`DATA_WIDTH-1:0] inst_addr,
    input  logic                   inst_gnt,
    input  logic                   inst_rvalid,
    input  logic [31:0]            inst_rdata,
    input  logic                   redirect_valid,
    input  logic [`DATA_WIDTH-1:0] redirect_pc,
    input  logic                   stall,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [`DATA_WIDTH-1:0] pc
);

    localparam int unsigned CW = $clog2(IF_DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = $bits(buf_entry_t);

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [`DATA_WIDTH-1:0] fetch_pc_q;
    logic [DROP_W-1:0]      drop_q;
    logic                   hs;
    logic                   rsp_stale;
    logic                   rsp_live;
    logic                   rsp_any;
    logic                   pop_en;
    logic                   tag_full;
    logic                   tag_empty;
    logic                   buf_full;
    logic                   buf_empty;
    logic [CW-1:0]          tag_cnt;
    logic [CW-1:0]          buf_cnt;
    logic [`DATA_WIDTH-1:0] tag_pc;
    logic [EW-1:0]          buf_head_raw;
    buf_entry_t             buf_head;
    buf_entry_t             buf_in;
    logic [OW-1:0]          occ_q;
    logic [OW-1:0]          occ_d;

    assign hs        = inst_req & inst_gnt;
    // Stale responses are always older than live ones, so they drain first.
    assign rsp_stale = inst_rvalid & (drop_q != '0);
    assign rsp_live  = inst_rvalid & (drop_q == '0) & ~tag_empty;
    assign rsp_any   = rsp_stale | rsp_live;

    assign inst_valid = ~buf_empty & ~redirect_valid;
    assign pop_en     = inst_valid & ~stall;
    assign buf_head   = buf_entry_t'(buf_head_raw);
    assign inst       = inst_valid ? buf_head.inst : '0;
    assign pc         = inst_valid ? buf_head.pc : '0;
    assign inst_addr  = fetch_pc_q;
    assign buf_in     = '{pc: tag_pc, inst: inst_rdata};

    // A pop this cycle frees a credit immediately, sustaining one fetch per cycle from HOLD.
    assign inst_req = rst_n & ~redirect_valid & ~tag_full & ((state_q == FETCH_RUN) | pop_en);

    // A response moves an entry from tag queue to buffer, leaving occupancy unchanged.
    assign occ_q = OW'(tag_cnt) + OW'(buf_cnt);

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q + OW'(hs) - OW'(pop_en);
        if (redirect_valid) begin
            occ_d   = '0;
            state_d = FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_RUN:  if (occ_d >= OW'(IF_DEPTH)) state_d = FETCH_HOLD;
                FETCH_HOLD: if (occ_d < OW'(IF_DEPTH)) state_d = FETCH_RUN;
                default:    state_d = FETCH_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_RUN;
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
            end else if (hs) begin
                fetch_pc_q <= fetch_pc_q + `DATA_WIDTH'(4);
            end
            // Every request still in flight becomes stale; one may retire this very cycle.
            if (redirect_valid) begin
                drop_q <= drop_q + DROP_W'(tag_cnt) - DROP_W'(rsp_any);
            end else if (rsp_stale) begin
                drop_q <= drop_q - DROP_W'(1);
            end
        end
    end

    if_fifo #(
        .DEPTH (IF_DEPTH),
        .WIDTH (`DATA_WIDTH)
    ) u_tag_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (hs),
        .push_dat (fetch_pc_q),
        .pop      (rsp_live),
        .head_dat (tag_pc),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_cnt)
    );

    if_fifo #(
        .DEPTH (IF_DEPTH),
        .WIDTH (EW)
    ) u_inst_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (rsp_live & ~buf_full),
        .push_dat (buf_in),
        .pop      (pop_en),
        .head_dat (buf_head_raw),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_cnt)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a queued instruction-memory model.
module tb_if_stage;

`ifdef IF_BUF2_EN
    localparam int SPACING = 1;
`else
    localparam int SPACING = 2;
`endif
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [63:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mem_hold;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int n_seen;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        int          cyc;
    } log_t;
    log_t        log_q[$];
    logic [63:0] mq[$];

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_gnt       (inst_gnt),
        .inst_rvalid    (inst_rvalid),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [63:0] a);
        return a[31:0] - 32'h8000_0000 + 32'h0050_0093;
    endfunction

    // Memory: answers in grant order, earliest the cycle after the grant.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            inst_rvalid <= 1'b0;
            inst_rdata  <= 32'h0;
        end else begin
            if (inst_req && inst_gnt) mq.push_back(inst_addr);
            if (!mem_hold && mq.size() > 0) begin
                inst_rvalid <= 1'b1;
                inst_rdata  <= model(mq.pop_front());
            end else begin
                inst_rvalid <= 1'b0;
                inst_rdata  <= 32'h0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (inst_valid && !stall) log_q.push_back('{pc: pc, inst: inst, cyc: cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic wait_log(input int n, input string tag);
        int b = 0;
        while (log_q.size() < n && b < 80) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk1(tag, log_q.size() >= n, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; inst_gnt = 1'b1; stall = 1'b0; mem_hold = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_inst_req", inst_req, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", 64'(inst), 64'h0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_inst_addr", inst_addr, BASE);

        // First fetch after reset release
        @(negedge clk); rst_n = 1'b1; log_q.delete(); #1;
        chk1("first_req", inst_req, 1'b1);
        chk("first_addr", inst_addr, BASE);
        repeat (2) @(negedge clk);
        #1;
        chk1("first_valid", inst_valid, 1'b1);
        chk("first_inst", 64'(inst), 64'h0050_0093);
        chk("first_pc", pc, BASE);

        // Streaming: 8 consecutive pcs at the configured rate
        wait_log(8, "fill_8");
        for (int i = 0; i < 8; i++) begin
            chk("seq_pc", log_q[i].pc, BASE + 64'(4 * i));
            chk("seq_inst", 64'(log_q[i].inst), 64'(model(BASE + 64'(4 * i))));
        end
        for (int i = 1; i < 8; i++)
            chk("seq_spacing", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'(SPACING));

        // Stall for 5 cycles
        @(negedge clk); stall = 1'b1; #1;
        n_seen = log_q.size();
        repeat (3) @(negedge clk);
        #1;
        chk1("stall_req", inst_req, 1'b0);
        chk1("stall_valid", inst_valid, 1'b1);
        chk("stall_pc", pc, BASE + 64'(4 * n_seen));
        chk("stall_inst", 64'(inst), 64'(model(BASE + 64'(4 * n_seen))));
        @(negedge clk); #1;
        chk1("stall_req_hold", inst_req, 1'b0);
        chk("stall_pc_hold", pc, BASE + 64'(4 * n_seen));
        @(negedge clk); stall = 1'b0;
        wait_log(n_seen + 4, "post_stall");
        for (int i = 0; i < log_q.size(); i++)
            chk("no_loss_pc", log_q[i].pc, BASE + 64'(4 * i));

        // Hold memory so requests stay outstanding, then redirect twice
        @(negedge clk); mem_hold = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk1("held_req", inst_req, 1'b0);
        chk1("held_valid", inst_valid, 1'b0);
        chk("held_inst_zero", 64'(inst), 64'h0);
        chk("held_pc_zero", pc, 64'h0);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; #1;
        chk1("redir1_req", inst_req, 1'b0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("redir1_addr", inst_addr, 64'h8000_2000);
        chk1("redir1_next_req", inst_req, 1'b1);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; #1;
        chk1("redir2_req", inst_req, 1'b0);
        @(negedge clk); redirect_valid = 1'b0; mem_hold = 1'b0; log_q.delete(); #1;
        chk("redir2_addr", inst_addr, 64'h8000_1000);
        wait_log(3, "redir2_drain");
        for (int i = 0; i < 3; i++) begin
            chk("redir2_pc", log_q[i].pc, 64'h8000_1000 + 64'(4 * i));
            chk("redir2_inst", 64'(log_q[i].inst), 64'(model(64'h8000_1000 + 64'(4 * i))));
        end

        // Grant withheld: address stable, then redirect while waiting
        @(negedge clk); inst_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; #1;
        chk1("gnt0_redir_req", inst_req, 1'b0);
        chk1("gnt0_redir_valid", inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); redirect_valid = 1'b0; #1;
            chk("gnt0_addr", inst_addr, 64'h8000_3000);
            chk1("gnt0_req", inst_req, 1'b1);
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_4000; #1;
        chk1("gnt0_redir2_req", inst_req, 1'b0);
        @(negedge clk); redirect_valid = 1'b0; inst_gnt = 1'b1; log_q.delete(); #1;
        chk("gnt0_new_addr", inst_addr, 64'h8000_4000);
        chk1("gnt0_new_req", inst_req, 1'b1);
        wait_log(2, "gnt0_drain");
        chk("gnt0_pc0", log_q[0].pc, 64'h8000_4000);
        chk("gnt0_pc1", log_q[1].pc, 64'h8000_4004);

        // Reset with requests in flight
        @(negedge clk); rst_n = 1'b0; #1;
        chk1("mrst_req", inst_req, 1'b0);
        chk1("mrst_valid", inst_valid, 1'b0);
        chk("mrst_inst", 64'(inst), 64'h0);
        chk("mrst_pc", pc, 64'h0);
        chk("mrst_addr", inst_addr, BASE);
        repeat (2) @(negedge clk);
        @(negedge clk); rst_n = 1'b1; log_q.delete(); #1;
        chk1("mrst_first_req", inst_req, 1'b1);
        chk("mrst_first_addr", inst_addr, BASE);
        wait_log(1, "mrst_drain");
        chk("mrst_first_pc", log_q[0].pc, BASE);
        chk("mrst_first_inst", 64'(log_q[0].inst), 64'h0050_0093);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low, released synchronously to clk by the system.
REQ-004 inst_req  output  1  fetch request valid to instruction memory.
REQ-005 inst_addr  output  `DATA_WIDTH  fetch address, 4-byte aligned.
REQ-006 inst_gnt  input  1  memory accepts request this cycle (handshake = inst_req & inst_gnt).
REQ-007 inst_rvalid  input  1  response valid; responses return in grant order, at least 1 cycle after grant.
REQ-008 inst_rdata  input  32  response instruction word.
REQ-009 redirect_valid  input  1  branch/jump/exception redirect from later stages.
REQ-010 redirect_pc  input  `DATA_WIDTH  new fetch address, 4-byte aligned.
REQ-011 stall  input  1  decode cannot accept an instruction this cycle.
REQ-012 inst_valid  output  1  inst/pc to decode are valid.
REQ-013 inst  output  32  instruction word to decode stage.
REQ-014 pc  output  `DATA_WIDTH  address of inst.

Function
REQ-015 Fetch PC register shall drive inst_addr and shall advance by 4 on every handshake; wrap-around at 2^64 is modular, no error.
REQ-016 inst_req and inst_addr shall stay stable until granted, except on redirect (REQ-022).
REQ-017 Instruction buffer (FIFO) depth DEPTH stores {pc, inst}; inst_req shall assert only when outstanding_count + occupancy < DEPTH, so a response never finds the buffer full.
REQ-018 Fetch FSM states: RUN (requests permitted), HOLD (credit exhausted, inst_req=0); RUN->HOLD when credits reach 0, HOLD->RUN when a credit frees.
REQ-019 A non-stale inst_rvalid shall push {pc of that request, inst_rdata} the same cycle; the pc travels with the request in an in-order tag queue.
REQ-020 inst_valid = buffer non-empty; inst/pc = head entry; head pops when inst_valid & ~stall; inst and pc shall be 0 when inst_valid=0.
REQ-021 Push and pop in the same cycle shall both take effect; minimum latency grant->inst_valid is rvalid cycle + 1.
REQ-022 On redirect_valid: buffer flushed, inst_valid forced 0 that cycle, fetch PC <= redirect_pc, inst_req deasserted that cycle, first new request next cycle.
REQ-023 Requests granted before or in the redirect cycle shall be marked stale (drop counter = outstanding count); their responses shall be discarded, not pushed.
REQ-024 Redirect coinciding with rvalid: response discarded. Redirect while drop counter non-zero: counter adds new outstanding grants.
REQ-025 Redirect has priority over pop, push and PC increment.

Reset
REQ-026 On rst_n=0: fetch PC=RESET_PC, buffer empty, outstanding and drop counters 0, FSM=RUN, inst_req=0, inst_valid=0, inst=0, pc=0.
REQ-027 inst_req shall first assert in the first cycle after rst_n rises; reset mid-operation abandons all outstanding requests without error.

Configuration
REQ-028 Macro IF_BUF2_EN defined: DEPTH=2, up to 2 outstanding requests (back-to-back fetch, 1 instr/cycle sustained with 1-cycle memory).
REQ-029 IF_BUF2_EN undefined: DEPTH=1, single outstanding request, at most one instruction every 2 cycles; all other behaviour identical.

Structure
REQ-030 Shared package holds RESET_PC default, DEPTH selection, fetch FSM state enum and the {pc, inst} buffer entry struct; `DATA_WIDTH stays in defines.sv.
REQ-031 Buffer shall be a sub-module if_fifo (parameterised depth, push/pop/flush, full/empty); tag queue reuses it.

Verification
REQ-032 Reset release, memory gnt=1, rvalid 1 cycle after grant with rdata=0x00500093 -> inst_addr=0x80000000 first cycle; inst_valid=1, inst=0x00500093, pc=0x80000000 two cycles later.
REQ-033 IF_BUF2_EN, stall=0, 1-cycle memory, 8 fetches -> pcs 0x80000000..0x8000001C consecutively, one per cycle after fill.
REQ-034 stall=1 held 5 cycles -> inst_req deasserts once credits exhausted; inst/pc held constant; no entry lost or duplicated after stall drops.
REQ-035 redirect_pc=0x80001000 with 2 requests outstanding -> both responses discarded, next inst_valid carries pc=0x80001000.
REQ-036 inst_gnt=0 for 3 cycles -> inst_addr stable; redirect during wait -> inst_addr=redirect_pc next cycle.
REQ-037 rst_n asserted with requests outstanding -> all outputs at reset values immediately; fetch restarts at 0x80000000.
